memory_ctrl: RTL and testbench
==============================

Name: memory_ctrl

Overview:
- Parametrised single-port synchronous data memory with a REQ/ACK handshake, programmable wait states and byte-lane write enables.
- Successor to the fixed 16-bit CPU memory. Sits between the CPU datapath (MA/MW/MWD/MD naming retained) and on-chip RAM, so the control FSM can stall on BUSY/ACK instead of assuming fixed one-cycle timing.

Parameters:
- DW, 16, data width in bits; must be a multiple of 8.
- AW, 8, address width in words; depth = 2^AW words.
- WAIT, 1, extra wait-state cycles per access; legal range 0..7.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- REQ  in  1  access request; sampled only in IDLE.
- MW  in  1  1 = write, 0 = read; latched with REQ.
- MA  in  AW  word address; latched with REQ.
- MWD  in  DW  write data; latched with REQ.
- BE  in  DW/8  byte enables for writes (bit i = bits 8i+7:8i); ignored for reads.
- ACK  out  1  one-cycle completion pulse; MD valid while ACK=1 and held afterwards.
- MD  out  DW  read data, or merged word after a write.
- BUSY  out  1  high while a request is in flight (state != IDLE).

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE, wait counter 0, ACK=0, MD=0, BUSY=0, latched request cleared. RAM contents are not reset and are undefined until written.
- FSM states are IDLE, WAITST and ACCESS.
- IDLE:
  - On the edge where REQ=1, latch MA/MW/MWD/BE.
  - Go to WAITST with counter = WAIT-1 if WAIT>0, otherwise go to ACCESS.
  - With REQ=0, stay in IDLE.
- WAITST: decrement the counter each edge. Leave for ACCESS on the edge where the counter is 0.
- ACCESS (exactly one edge):
  - Read: MD <= RAM[MA_latched].
  - Write: RAM[MA_latched] <= per-byte merge of MWD_latched (BE=1) and old word (BE=0). MD <= the merged word.
  - ACK <= 1, next state IDLE.
- ACK is high for exactly one cycle, then clears on the next edge.
- Latency: request accepted at edge N; ACK and MD are valid after edge N+WAIT+1.
- Throughput: REQ held high during the ACK cycle is accepted at that edge (back-to-back). The minimum request period is WAIT+2 cycles.
- REQ while BUSY=1 is ignored, not queued. MA/MW/MWD/BE changes while BUSY are ignored because they were already latched.
- A write with BE all zero modifies no bytes. ACK is still issued and MD returns the unchanged word.
- A read following a write to the same address returns the new data with no hazard, because accesses are serialised.
- Reset asserted in WAITST or ACCESS before the ACCESS edge aborts the operation: no RAM write, no ACK.
- MD retains its last value between ACKs. It never changes except at the ACCESS edge or on reset.
- Combinational paths: none from inputs to outputs. ACK, MD and BUSY are registered or decoded from state.

Test Plan (DW=16, AW=8 unless noted):
- Reset: drive RST_N low mid-cycle -> ACK=0, MD=0x0000, BUSY=0 immediately, without waiting for a clock edge.
- WAIT=1 write: REQ=1, MW=1, MA=5, MWD=0x001F, BE=2'b11 accepted at edge N -> BUSY=1 after edge N; ACK=1 and MD=0x001F after edge N+2; ACK=0 after edge N+3. Then read MA=5 -> MD=0x001F.
- Byte lanes: RAM[7]=0x1234, then write MWD=0xABCD with BE=2'b01 -> MD=0x12CD; following read of address 7 -> 0x12CD. Write with BE=2'b00 -> MD=0x12CD, ACK still pulses.
- Ignore while busy: with WAIT=3, pulse a second REQ (write 0xFFFF to MA=9) while BUSY=1 -> exactly one ACK; a later read of 9 shows the prior contents.
- Reset mid-operation: write 0x5555 to MA=3 over a prior 0x0001, assert RST_N low during WAITST -> no ACK; after release, read of 3 returns 0x0001.
- WAIT=0 back-to-back: hold REQ=1 with read, MA=0,1,2 on successive accepts -> ACK every 2nd cycle, MD sequence matches RAM[0..2], no dropped request.

Source files
------------

// File: rtl/memory_ctrl.sv
// Single-port data memory with REQ/ACK handshake, programmable wait states
// and byte-lane write enables. Accesses are strictly serialised.
module memory_ctrl #(
    parameter int DW   = 16,
    parameter int AW   = 8,
    parameter int WAIT = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            REQ,
    input  logic            MW,
    input  logic [AW-1:0]   MA,
    input  logic [DW-1:0]   MWD,
    input  logic [DW/8-1:0] BE,
    output logic            ACK,
    output logic [DW-1:0]   MD,
    output logic            BUSY
);
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [2:0] WAIT_LOAD = 3'((WAIT > 0) ? WAIT - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAITST, ACCESS} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      cnt_reg, cnt_next;

    logic            mw_reg;
    logic [AW-1:0]   ma_reg;
    logic [DW-1:0]   wd_reg;
    logic [NB-1:0]   be_reg;
    logic            ack_reg;
    logic [DW-1:0]   md_reg;

    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   rd_reg;
    logic [DW-1:0]   merged;

    logic            accept;
    logic            do_access;
    logic            busy;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (REQ) begin
                    if (WAIT > 0) begin
                        state_next = WAITST;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            WAITST: begin
                if (cnt_reg == 3'd0) begin
                    state_next = ACCESS;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        accept    = 1'b0;
        do_access = 1'b0;
        busy      = 1'b1;
        case (state_reg)
            IDLE: begin
                accept = REQ;
                busy   = 1'b0;
            end
            ACCESS:  do_access = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mw_reg  <= 1'b0;
            ma_reg  <= '0;
            wd_reg  <= '0;
            be_reg  <= '0;
            ack_reg <= 1'b0;
            md_reg  <= '0;
        end else begin
            if (accept) begin
                mw_reg <= MW;
                ma_reg <= MA;
                wd_reg <= MWD;
                be_reg <= BE;
            end
            ack_reg <= do_access;
            if (do_access) begin
                md_reg <= mw_reg ? merged : rd_reg;
            end
        end
    end

    // The old word is fetched on the accept edge, so the write merge at the
    // ACCESS edge only ever needs a registered read of the RAM.
    always_ff @(posedge CLK) begin
        if (accept) begin
            rd_reg <= mem[MA];
        end
        if (do_access && mw_reg) begin
            mem[ma_reg] <= merged;
        end
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign merged[8*gi +: 8] = be_reg[gi] ? wd_reg[8*gi +: 8] : rd_reg[8*gi +: 8];
        end
    endgenerate

    assign ACK  = ack_reg;
    assign MD   = md_reg;
    assign BUSY = busy;

endmodule

// File: tb/tb_memory_ctrl.sv
// Bench for memory_ctrl: three instances (WAIT=1, 3, 0) driven with directed
// and random transactions, checked against a word-array reference model.
module tb_memory_ctrl;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a  [NI];
    logic        req_a  [NI];
    logic        mw_a   [NI];
    logic [7:0]  ma_a   [NI];
    logic [15:0] wd_a   [NI];
    logic [1:0]  be_a   [NI];
    logic        ack_a  [NI];
    logic [15:0] md_a   [NI];
    logic        busy_a [NI];

    logic [15:0] mem_m [NI][256];

    int n_vec = 0;
    int n_bad = 0;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            memory_ctrl #(
                .DW(16), .AW(8), .WAIT(gi == 0 ? 1 : (gi == 1 ? 3 : 0))
            ) u_dut (
                .CLK(clk), .RST_N(rst_a[gi]), .REQ(req_a[gi]), .MW(mw_a[gi]),
                .MA(ma_a[gi]), .MWD(wd_a[gi]), .BE(be_a[gi]),
                .ACK(ack_a[gi]), .MD(md_a[gi]), .BUSY(busy_a[gi])
            );
        end
    endgenerate

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] b);
        logic [15:0] r;
        r = old;
        for (int i = 0; i < 2; i++) begin
            if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // One full request: issue, scramble inputs while busy, time the ACK,
    // then confirm the pulse drops and MD holds.
    task automatic txn(input int k, input bit w, input logic [7:0] a,
                       input logic [15:0] d, input logic [1:0] b);
        int off;
        logic [15:0] exp_md;
        if (w) begin
            exp_md = merge(mem_m[k][a], d, b);
            mem_m[k][a] = exp_md;
        end else begin
            exp_md = mem_m[k][a];
        end
        @(negedge clk);
        req_a[k] = 1'b1; mw_a[k] = w; ma_a[k] = a; wd_a[k] = d; be_a[k] = b;
        @(negedge clk);
        req_a[k] = 1'b0;
        mw_a[k] = 1'($urandom); ma_a[k] = 8'($urandom);
        wd_a[k] = 16'($urandom); be_a[k] = 2'($urandom);
        check_val("busy_after_accept", 32'(busy_a[k]), 32'd1);
        off = 0;
        while (!ack_a[k] && off < 20) begin
            @(negedge clk);
            off++;
        end
        check_val("ack_latency", 32'(off), 32'(wait_of(k) + 1));
        check_val(w ? "md_write" : "md_read", 32'(md_a[k]), 32'(exp_md));
        $display("txn dut%0d %s addr=%02h wd=%04h be=%b md=%04h lat=%0d",
                 k, w ? "WR" : "RD", a, d, b, md_a[k], off);
        @(negedge clk);
        check_val("ack_one_cycle", 32'(ack_a[k]), 32'd0);
        check_val("md_hold", 32'(md_a[k]), 32'(exp_md));
    endtask

    initial begin
        int acks;
        for (int k = 0; k < NI; k++) begin
            rst_a[k] = 1'b0; req_a[k] = 1'b0; mw_a[k] = 1'b0;
            ma_a[k] = '0; wd_a[k] = '0; be_a[k] = '0;
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            check_val("reset_ack", 32'(ack_a[k]), 32'd0);
            check_val("reset_md", 32'(md_a[k]), 32'd0);
            check_val("reset_busy", 32'(busy_a[k]), 32'd0);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) rst_a[k] = 1'b1;

        // Initialise low addresses so later reads are well defined
        for (int k = 0; k < NI; k++)
            for (int a = 0; a < 16; a++)
                txn(k, 1'b1, 8'(a), 16'($urandom), 2'b11);

        // WAIT=1 write then read back
        txn(0, 1'b1, 8'd5, 16'h001F, 2'b11);
        txn(0, 1'b0, 8'd5, 16'h0000, 2'b00);

        // Byte lanes
        txn(0, 1'b1, 8'd7, 16'h1234, 2'b11);
        txn(0, 1'b1, 8'd7, 16'hABCD, 2'b01);
        txn(0, 1'b0, 8'd7, 16'h0000, 2'b00);
        txn(0, 1'b1, 8'd7, 16'h5A5A, 2'b00);

        // Second REQ while busy must be dropped (WAIT=3 instance)
        txn(1, 1'b1, 8'd9, 16'h2468, 2'b11);
        @(negedge clk);
        req_a[1] = 1'b1; mw_a[1] = 1'b1; ma_a[1] = 8'd10; wd_a[1] = 16'h1357; be_a[1] = 2'b11;
        mem_m[1][10] = 16'h1357;
        @(negedge clk);
        ma_a[1] = 8'd9; wd_a[1] = 16'hFFFF;
        check_val("busy_during_ignore", 32'(busy_a[1]), 32'd1);
        acks = 0;
        @(negedge clk);
        req_a[1] = 1'b0;
        if (ack_a[1]) acks++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_a[1]) acks++;
        end
        check_val("busy_ignore_acks", 32'(acks), 32'd1);
        check_val("busy_ignore_md", 32'(md_a[1]), 32'h1357);
        $display("txn dut1 WR addr=0a with ignored WR addr=09 acks=%0d", acks);
        txn(1, 1'b0, 8'd9, 16'h0000, 2'b00);
        txn(1, 1'b0, 8'd10, 16'h0000, 2'b00);

        // Reset during WAITST aborts the write
        txn(0, 1'b1, 8'd3, 16'h0001, 2'b11);
        @(negedge clk);
        req_a[0] = 1'b1; mw_a[0] = 1'b1; ma_a[0] = 8'd3; wd_a[0] = 16'h5555; be_a[0] = 2'b11;
        @(negedge clk);
        req_a[0] = 1'b0;
        check_val("busy_before_abort", 32'(busy_a[0]), 32'd1);
        #2 rst_a[0] = 1'b0;
        #1;
        check_val("async_reset_ack", 32'(ack_a[0]), 32'd0);
        check_val("async_reset_md", 32'(md_a[0]), 32'd0);
        check_val("async_reset_busy", 32'(busy_a[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_a[0] = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_a[0]) acks++;
        end
        check_val("abort_no_ack", 32'(acks), 32'd0);
        $display("txn dut0 WR addr=03 aborted by reset acks=%0d", acks);
        txn(0, 1'b0, 8'd3, 16'h0000, 2'b00);

        // WAIT=0 back-to-back reads with REQ held high
        @(negedge clk);
        req_a[2] = 1'b1; mw_a[2] = 1'b0; ma_a[2] = 8'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("b2b_ack", 32'(ack_a[2]), 32'(i % 2));
            if (i % 2 == 1) begin
                check_val("b2b_md", 32'(md_a[2]), 32'(mem_m[2][i/2]));
                $display("txn dut2 RD addr=%02h md=%04h back-to-back", 8'(i/2), md_a[2]);
            end else if (i == 4) begin
                req_a[2] = 1'b0;
            end else begin
                ma_a[2] = 8'(i/2 + 1);
            end
        end
        @(negedge clk);
        check_val("b2b_ack_end", 32'(ack_a[2]), 32'd0);

        // Random traffic on all instances
        for (int n = 0; n < 60; n++) begin
            txn($urandom_range(0, NI-1), 1'($urandom), 8'($urandom_range(0, 15)),
                16'($urandom), 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
